// File: rtl/decode_hazard_if.sv
// Decode hazard unit bundle: pipeline-side inputs
// and the mux/freeze/counter outputs it drives.
interface decode_hazard_if #(
  parameter int NB_REG = 5,
  parameter int NB_SRC = 2,
  parameter int NB_CNT = 32
);
  logic                     i_enable;
  logic [NB_SRC*NB_REG-1:0] i_src_regs;
  logic [NB_SRC-1:0]        i_src_used;
  logic                     i_is_branch;
  logic                     i_id_ex_reg_write;
  logic                     i_id_ex_mem_read;
  logic [NB_REG-1:0]        i_id_ex_write_reg;
  logic                     i_ex_mem_reg_write;
  logic                     i_ex_mem_mem_read;
  logic [NB_REG-1:0]        i_ex_mem_write_reg;
  logic                     i_mem_wb_reg_write;
  logic [NB_REG-1:0]        i_mem_wb_write_reg;
  logic [2*NB_SRC-1:0]      o_fwd_sel;
  logic                     o_stall;
  logic                     o_bubble;
  logic [NB_CNT-1:0]        o_stall_cycles;
  logic [NB_CNT-1:0]        o_fwd_count;

  modport master (
    output i_enable, i_src_regs, i_src_used,
    output i_is_branch,
    output i_id_ex_reg_write, i_id_ex_mem_read,
    output i_id_ex_write_reg,
    output i_ex_mem_reg_write, i_ex_mem_mem_read,
    output i_ex_mem_write_reg,
    output i_mem_wb_reg_write, i_mem_wb_write_reg,
    input  o_fwd_sel, o_stall, o_bubble,
    input  o_stall_cycles, o_fwd_count
  );

  modport slave (
    input  i_enable, i_src_regs, i_src_used,
    input  i_is_branch,
    input  i_id_ex_reg_write, i_id_ex_mem_read,
    input  i_id_ex_write_reg,
    input  i_ex_mem_reg_write, i_ex_mem_mem_read,
    input  i_ex_mem_write_reg,
    input  i_mem_wb_reg_write, i_mem_wb_write_reg,
    output o_fwd_sel, o_stall, o_bubble,
    output o_stall_cycles, o_fwd_count
  );
endinterface

// File: rtl/decode_hazard_unit.sv
// Decode-stage forwarding select, load-use/branch
// stall detection and saturating perf counters.
module decode_hazard_unit #(
  parameter int NB_REG = 5,
  parameter int NB_SRC = 2,
  parameter int NB_CNT = 32
) (
  input logic             clock,
  input logic             reset,
  decode_hazard_if.slave  bus
);

  typedef enum logic {RUN, HOLD} state_t;

  localparam logic [NB_CNT-1:0] CNT_ONE =
    {{(NB_CNT-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [1:0]          rem_q, rem_d;
  logic [NB_CNT-1:0]   sc_q, sc_d;
  logic [NB_CNT-1:0]   fc_q, fc_d;
  logic [NB_SRC-1:0]   m_ex, m_mem, m_wb;
  logic [2*NB_SRC-1:0] fwd_sel;
  logic [1:0]          need;
  logic                stall;
  logic                any_ex, any_mem;

  for (genvar k = 0; k < NB_SRC; k++) begin : g_src
    logic [NB_REG-1:0] src;
    logic              used;
    assign src  = bus.i_src_regs[k*NB_REG +: NB_REG];
    assign used = bus.i_src_used[k] && (src != '0);
    assign m_ex[k] = used && bus.i_id_ex_reg_write
      && (bus.i_id_ex_write_reg == src);
    assign m_mem[k] = used && bus.i_ex_mem_reg_write
      && (bus.i_ex_mem_write_reg == src);
    assign m_wb[k] = used && bus.i_mem_wb_reg_write
      && (bus.i_mem_wb_write_reg == src);
    assign fwd_sel[2*k +: 2] =
      (m_mem[k] && !bus.i_ex_mem_mem_read) ? 2'b01 :
      m_wb[k]                              ? 2'b10 :
                                             2'b00;
  end

  assign any_ex  = |m_ex;
  assign any_mem = |m_mem;

  // Stall need: first matching hazard row wins
  always_comb begin
    need = 2'd0;
    unique case (1'b1)
      (bus.i_is_branch && any_ex
        && bus.i_id_ex_mem_read):  need = 2'd2;
      (any_ex && bus.i_id_ex_mem_read
        && !bus.i_is_branch):      need = 2'd1;
      (bus.i_is_branch && any_ex
        && !bus.i_id_ex_mem_read): need = 2'd1;
      (bus.i_is_branch && !any_ex && any_mem
        && bus.i_ex_mem_mem_read): need = 2'd1;
      default:                     need = 2'd0;
    endcase
  end

  // Stall FSM: RUN stalls on need, HOLD extends it
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    stall   = 1'b0;
    unique case (state_q)
      RUN: begin
        stall = (need != 2'd0);
        if (bus.i_enable && need >= 2'd2) begin
          state_d = HOLD;
          rem_d   = need - 2'd1;
        end
      end
      HOLD: begin
        stall = 1'b1;
        if (bus.i_enable) begin
          rem_d = rem_q - 2'd1;
          if (rem_d == 2'd0) state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Saturating stall and forward counters
  always_comb begin
    sc_d = sc_q;
    fc_d = fc_q;
    if (bus.i_enable) begin
      if (stall && !(&sc_q)) sc_d = sc_q + CNT_ONE;
      if (!stall && (|fwd_sel) && !(&fc_q))
        fc_d = fc_q + CNT_ONE;
    end
  end

  // State and counter registers, sync reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      rem_q   <= 2'd0;
      sc_q    <= '0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sc_q    <= sc_d;
      fc_q    <= fc_d;
    end
  end

  assign bus.o_fwd_sel      = fwd_sel;
  assign bus.o_stall        = stall;
  assign bus.o_bubble       = stall;
  assign bus.o_stall_cycles = sc_q;
  assign bus.o_fwd_count    = fc_q;

endmodule

// File: doc/decode_hazard_unit.md
Name: decode_hazard_unit

Overview:
- Decode-stage hazard and forwarding controller for the MIPS pipeline.
- Supersedes the single-source, single-stage decode forward with:
  - NB_SRC source operands;
  - two forwarding sources, EX/MEM and MEM/WB, with priority;
  - load-use and branch-in-decode stall detection;
  - a multi-cycle stall FSM;
  - saturating stall and forward performance counters readable by the debug unit.
- Sits beside the ID stage and drives the decode operand muxes, the PC/IF-ID freeze and the ID/EX bubble.

Parameters:
- NB_REG, 5, register index width.
- NB_SRC, 2, number of decode source operands checked.
- NB_CNT, 32, performance counter width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- i_enable  in  1  pipeline step enable from the debug unit. When 0, the FSM and counters hold.
- i_src_regs  in  NB_SRC*NB_REG  decode source register indices; operand k occupies bits [k*NB_REG +: NB_REG].
- i_src_used  in  NB_SRC  bit k set when operand k is actually read.
- i_is_branch  in  1  decode instruction is a branch resolved in ID.
- i_id_ex_reg_write  in  1  instruction in EX writes a register.
- i_id_ex_mem_read  in  1  instruction in EX is a load.
- i_id_ex_write_reg  in  NB_REG  destination of the instruction in EX.
- i_ex_mem_reg_write  in  1  instruction in MEM writes a register.
- i_ex_mem_mem_read  in  1  instruction in MEM is a load.
- i_ex_mem_write_reg  in  NB_REG  destination of the instruction in MEM.
- i_mem_wb_reg_write  in  1  instruction in WB writes a register.
- i_mem_wb_write_reg  in  NB_REG  destination of the instruction in WB.
- o_fwd_sel  out  2*NB_SRC  per operand: 00 regfile, 01 EX/MEM, 10 MEM/WB.
- o_stall  out  1  freeze the PC and the IF/ID register.
- o_bubble  out  1  insert a NOP into ID/EX; always equals o_stall.
- o_stall_cycles  out  NB_CNT  count of enabled stalled cycles.
- o_fwd_count  out  NB_CNT  count of enabled non-stalled cycles with any forward selected.

Behaviour:
- Match rule: operand k matches stage S when all of these hold:
  - i_src_used[k] = 1;
  - the operand index is nonzero;
  - S reg_write = 1;
  - the S destination equals the operand index.
  - Register 0 never matches.
- Forward select, combinational, per operand:
  - 01 on an EX/MEM match with i_ex_mem_mem_read = 0;
  - else 10 on a MEM/WB match;
  - else 00.
  - EX/MEM has priority over MEM/WB.
  - A load match in EX/MEM never selects 01.
- Stall need N, computed combinationally from current inputs. The first applicable row wins:
  - 2 when i_is_branch = 1 and any operand matches EX with i_id_ex_mem_read = 1.
  - 1 when any operand matches EX with i_id_ex_mem_read = 1 (load-use).
  - 1 when i_is_branch = 1 and any operand matches EX (ALU result not ready for the ID compare).
  - 1 when i_is_branch = 1 and any operand matches MEM with i_ex_mem_mem_read = 1.
  - 0 otherwise.
- FSM states: RUN, HOLD. Internal 2-bit remaining counter rem.
  - RUN: o_stall = (N != 0), combinational. If i_enable = 1 and N >= 2, go to HOLD with rem = N-1. Otherwise stay in RUN.
  - HOLD: o_stall = 1 regardless of inputs. If i_enable = 1: decrement rem; when rem reaches 0, go to RUN. The next cycle re-evaluates N normally.
  - i_enable = 0: state and rem hold. Outputs are still driven from the current state and inputs.
- While o_stall = 1, o_fwd_sel is still driven per the forward rules. Downstream ignores it because IF/ID is frozen.
- Counters, on each cycle with i_enable = 1:
  - o_stall_cycles increments when o_stall = 1.
  - o_fwd_count increments when o_stall = 0 and o_fwd_sel != 0.
  - Both saturate at all-ones and never wrap.
- Reset, including mid-HOLD: on the next edge the FSM goes to RUN, rem = 0 and both counters = 0. o_stall and o_fwd_sel are then purely combinational from inputs. With all reg_write inputs at 0 they are 0.
- Latency: forward select and first-cycle stall are 0-cycle, combinational. The extended stall is registered.

Test Plan:
1. EX/MEM writes r5 (not a load), MEM/WB writes r5, src0 = r5 used -> o_fwd_sel[1:0] = 01, o_stall = 0, o_fwd_count +1.
2. Src0 = r0, all stages write r0 -> o_fwd_sel = 0, o_stall = 0, counters unchanged.
3. EX is a load to r7, non-branch src1 = r7 -> o_stall = 1 for exactly 1 cycle; then, with inputs advanced, load in MEM -> o_fwd_sel[3:2] = 00 (load in MEM not forwarded). After WB -> 10. o_stall_cycles = 1.
4. Branch with src0 = r3, EX load to r3 -> o_stall high 2 consecutive cycles; the FSM reaches HOLD and returns to RUN; o_stall_cycles = 2.
5. Repeat scenario 4 with i_enable = 0 for 3 cycles during HOLD -> o_stall held high, counters frozen, total stall still 2 enabled cycles.
6. Assert reset during HOLD -> next cycle FSM in RUN, counters 0; preload near all-ones (NB_CNT = 4) and stall 20 cycles -> o_stall_cycles = 15.
